text_console_ctrl: RTL

//  Sequencer that turns a byte stream of ASCII characters into writes to the

---
 rtl/text_console_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/text_console_ctrl.sv
// text_console_ctrl
//   Turns a stream of ASCII bytes into writes to the character RAM that feeds
//   the NTSC text renderer. It tracks the cursor, handles CR/LF/BS, wraps long
//   lines, and clears the screen. Scrolling is done by rotating top_row, which
//   the renderer adds to its row index, so no text ever has to be copied.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   char_valid  char_data holds a byte to accept
//   char_data   ASCII byte
//   char_ready  byte accepted on char_valid & char_ready
//   clear       single-cycle clear-screen request
//   busy        controller is clearing (not idle)
//   wr_en       char RAM write strobe (registered)
//   wr_addr     char RAM address {physical_row, col} (registered)
//   wr_data     char RAM write byte (registered)
//   cursor_col  logical cursor column
//   cursor_row  logical cursor row, 0 = top of screen
//   top_row     physical row displayed at the top of the screen
module text_console_ctrl #(
  parameter int         COLS     = 64,
  parameter int         ROWS     = 4,
  parameter logic [7:0] CLR_CHAR = 8'h20,
  localparam int        COL_W    = $clog2(COLS),
  localparam int        ROW_W    = $clog2(ROWS),
  localparam int        ADDR_W   = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clear,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [ROW_W-1:0]  top_row
);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  state_t             state, next_state;
  logic [ADDR_W-1:0]  cnt, nxt_cnt;
  logic [ROW_W-1:0]   clear_row, nxt_clear_row;
  logic               nxt_wr_en;
  logic [ADDR_W-1:0]  nxt_wr_addr;
  logic [7:0]         nxt_wr_data;
  logic [COL_W-1:0]   nxt_col;
  logic [ROW_W-1:0]   nxt_row, nxt_top;
  logic [ROW_W-1:0]   phys_row;
  logic               accept, is_cr, is_bs, is_lf, printable, line_adv, scroll;

  assign char_ready = (state == IDLE) & ~clear;
  assign busy       = (state != IDLE);
  assign accept     = char_valid & char_ready;
  assign phys_row   = top_row + cursor_row;

  // Byte decode; a printable byte at the last column wraps like a LF.
  assign is_cr     = (char_data == 8'h0D);
  assign is_bs     = (char_data == 8'h08);
  assign is_lf     = (char_data == 8'h0A);
  assign printable = ~is_cr & ~is_bs & ~is_lf;
  assign line_adv  = is_lf | (printable & (cursor_col == LAST_COL));
  assign scroll    = accept & line_adv & (cursor_row == LAST_ROW);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLEAR_ALL;
    else          state <= next_state;
  end

  // Next-state logic: clear overrides everything and restarts the full wipe.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = CLEAR_ALL;
    end else begin
      case (state)
        CLEAR_ALL:  if (cnt == LAST_CNT) next_state = IDLE;
        IDLE:       if (scroll) next_state = CLEAR_LINE;
        CLEAR_LINE: if (cnt[COL_W-1:0] == LAST_COL) next_state = IDLE;
        default:    next_state = CLEAR_ALL;
      endcase
    end
  end

  // Output logic: computes the next value of every registered output and of
  // the cursor/scroll bookkeeping. Scrolling only bumps top_row; the row that
  // just left the top becomes the new bottom line and is wiped in CLEAR_LINE.
  always_comb begin
    nxt_cnt       = cnt;
    nxt_clear_row = clear_row;
    nxt_wr_en     = 1'b0;
    nxt_wr_addr   = wr_addr;
    nxt_wr_data   = wr_data;
    nxt_col       = cursor_col;
    nxt_row       = cursor_row;
    nxt_top       = top_row;
    if (clear) begin
      nxt_cnt = '0;
      nxt_col = '0;
      nxt_row = '0;
      nxt_top = '0;
    end else begin
      case (state)
        CLEAR_ALL: begin
          nxt_wr_en   = 1'b1;
          nxt_wr_addr = cnt;
          nxt_wr_data = CLR_CHAR;
          nxt_cnt     = cnt + 1'b1;
        end
        IDLE: begin
          if (accept) begin
            if (is_cr) begin
              nxt_col = '0;
            end else if (is_bs) begin
              if (cursor_col != '0) nxt_col = cursor_col - 1'b1;
            end else begin
              if (printable) begin
                nxt_wr_en   = 1'b1;
                nxt_wr_addr = {phys_row, cursor_col};
                nxt_wr_data = char_data;
                nxt_col     = cursor_col + 1'b1;
              end
              if (line_adv) begin
                nxt_col = '0;
                if (cursor_row != LAST_ROW) begin
                  nxt_row = cursor_row + 1'b1;
                end else begin
                  nxt_top       = top_row + 1'b1;
                  nxt_clear_row = top_row;
                  nxt_cnt       = '0;
                end
              end
            end
          end
        end
        CLEAR_LINE: begin
          nxt_wr_en   = 1'b1;
          nxt_wr_addr = {clear_row, cnt[COL_W-1:0]};
          nxt_wr_data = CLR_CHAR;
          nxt_cnt     = cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset values make the screen wipe start right away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      clear_row  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= CLR_CHAR;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
    end else begin
      cnt        <= nxt_cnt;
      clear_row  <= nxt_clear_row;
      wr_en      <= nxt_wr_en;
      wr_addr    <= nxt_wr_addr;
      wr_data    <= nxt_wr_data;
      cursor_col <= nxt_col;
      cursor_row <= nxt_row;
      top_row    <= nxt_top;
    end
  end

endmodule
